pianotiles_io_axil_regs: RTL and testbench
==========================================

Name: pianotiles_io_axil_regs

Overview:
AXI4-Lite slave register file that answers the master VIP / PS master on the pianotiles_io S00_AXI port. It holds four read/write 32-bit registers (LED drive, control, two scratch registers) and drives LED outputs from register 0. Write-address, write-data and read channels are accepted independently. It sits between the AXI interconnect and the board I/O pins of the Piano-Tiles game.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte-address width; decodes offsets 0x00–0x1C.
LED_W, 8, number of LED outputs driven from REG0[LED_W-1:0].
BTN_W, 4, number of button inputs; used only with the optional feature.

Ports:
ACLK  in  1  system clock
ARESET  in  1  asynchronous, active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake
S_AXI_BRESP  out  2  write response (OKAY=00, SLVERR=10)
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake
led_o  out  LED_W  equals REG0[LED_W-1:0], registered
btn_i  in  BTN_W  raw asynchronous buttons (feature only)
irq_o  out  1  level interrupt (feature only)

Behaviour:
- Reset (asynchronous, active-high): all registers, REG0–REG3, led_o, BVALID, RVALID, RDATA, BRESP, RRESP, irq_o = 0. All READY signals = 0 during reset and 1 in the first cycle after deassertion.
- Register map (word index = ADDR[4:2]; ADDR[1:0] ignored):
  - 0x00 REG0 LED
  - 0x04 REG1 CTRL
  - 0x08 REG2 scratch
  - 0x0C REG3 scratch
  - 0x10 BTN_STATUS (feature)
  - 0x14 BTN_EVENT W1C (feature)
  - any other offset is unmapped.
- Write path:
  - AWREADY is high while no address is latched and BVALID=0.
  - WREADY is high while no data is latched and BVALID=0.
  - AW and W may arrive in the same cycle or in either order, with any gap between them.
  - In the cycle after both are latched: registers update per WSTRB (byte lanes with strobe 0 keep their value), BVALID rises, BRESP = OKAY for mapped offsets and SLVERR for unmapped ones. An unmapped write changes no state.
  - BVALID and BRESP are held until BREADY. Only one write is outstanding at a time.
- Read path:
  - ARREADY = !RVALID.
  - Accepting AR sets RVALID on the next edge, with RDATA = the register value at that edge; RRESP = SLVERR and RDATA = 0 for unmapped offsets.
  - RVALID, RDATA and RRESP are held until RREADY.
- Ordering and timing:
  - A write and a read to the same register completing on the same edge: the read returns the old value.
  - led_o updates one cycle after REG0 changes.
  - Minimum latency: AW+W accept → BVALID = 1 cycle; AR accept → RVALID = 1 cycle.
  - ARESET asserted mid-transaction aborts everything; no response is ever issued for the aborted transaction.

Optional Feature:
- Macro: PIANOTILES_IO_BTN_IRQ_EN.
- When defined:
  - btn_i passes through a 2-flop synchronizer.
  - BTN_STATUS (0x10, read-only; writes return OKAY and are ignored) returns the synchronized levels.
  - BTN_EVENT (0x14) sets bit n on a synchronized rising edge of btn_i[n]. Writing 1 clears the bit. If a set and a clear hit the same bit in the same cycle, set wins.
  - irq_o = REG1[0] & |BTN_EVENT, registered.
- When undefined: 0x10 and 0x14 are unmapped (SLVERR), irq_o is tied to 0, and btn_i is unused.

Decomposition:
- Package pianotiles_io_pkg holds:
  - register offset localparams (REG0_OFF…BTN_EVENT_OFF);
  - AXI response constants RESP_OKAY / RESP_SLVERR;
  - the register index typedef.
- One sub-module, pianotiles_btn_sync: per-bit 2-flop synchronizer plus rising-edge pulse. It is instantiated only under the macro.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x00/0x04/0x08/0x0C, then read back → RDATA 0x1..0x4, all RRESP/BRESP OKAY; led_o = 0x01.
- AWVALID at cycle 0, WVALID at cycle 3 (data 0xA5) to 0x08 → BVALID exactly 1 cycle after the W handshake; a later read of 0x08 returns 0xA5.
- REG2 = 0xFFFFFFFF, then write 0x12345678 with WSTRB = 0b0101 → reading back gives 0xFF34FF78.
- BREADY/RREADY held low for 5 cycles → BVALID/RVALID and data stay stable; AWREADY/ARREADY stay low until the response handshake completes.
- Write/read to 0x18 → BRESP = SLVERR, RRESP = SLVERR, RDATA = 0, REG0–REG3 unchanged.
- With the macro defined: set REG1 = 1, pulse btn_i[2] → BTN_EVENT = 0x4 and irq_o = 1 within 4 cycles; write 0x4 to 0x14 → BTN_EVENT = 0 and irq_o = 0.

Source files
------------

// File: rtl/pianotiles_io_pkg.sv
// pianotiles_io_pkg: shared constants and types for the pianotiles_io AXI4-Lite
// register block.
//   - byte offsets of every decoded register
//   - AXI response codes
//   - reg_idx_t: word index (ADDR[4:2]) of the register map
//   - helpers: offset -> index, WSTRB -> 32-bit byte mask
package pianotiles_io_pkg;

  localparam logic [4:0] REG0_OFF       = 5'h00;  // LED drive
  localparam logic [4:0] REG1_OFF       = 5'h04;  // control, bit0 = irq enable
  localparam logic [4:0] REG2_OFF       = 5'h08;  // scratch
  localparam logic [4:0] REG3_OFF       = 5'h0C;  // scratch
  localparam logic [4:0] BTN_STATUS_OFF = 5'h10;  // synced button levels (RO)
  localparam logic [4:0] BTN_EVENT_OFF  = 5'h14;  // rising-edge events (W1C)

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDX_REG0       = 3'd0,
    IDX_REG1       = 3'd1,
    IDX_REG2       = 3'd2,
    IDX_REG3       = 3'd3,
    IDX_BTN_STATUS = 3'd4,
    IDX_BTN_EVENT  = 3'd5,
    IDX_RSVD6      = 3'd6,
    IDX_RSVD7      = 3'd7
  } reg_idx_t;

  // Byte offset to word index; the low two address bits are don't-care.
  function automatic reg_idx_t off_to_idx(input logic [4:0] off);
    return reg_idx_t'(off[4:2]);
  endfunction

  // Expand 4 byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/pianotiles_btn_sync.sv
// pianotiles_btn_sync: one button bit -> 2-flop synchronizer + rising-edge pulse.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   async_i   : raw asynchronous button level
//   sync_o    : synchronized level (2 flops after async_i)
//   rise_o    : one-cycle pulse on a synchronized 0->1 transition
module pianotiles_btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  // sr[0..1] are the synchronizer, sr[2] is the previous synced level.
  logic [2:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sr <= '0;
    else     sr <= {sr[1:0], async_i};
  end

  assign sync_o = sr[1];
  assign rise_o = sr[1] & ~sr[2];

endmodule

// File: rtl/pianotiles_io_axil_regs.sv
// pianotiles_io_axil_regs: AXI4-Lite slave register file for the Piano-Tiles
// board I/O.
//   REG0 (0x00) LED drive, REG1 (0x04) control, REG2/REG3 (0x08/0x0C) scratch.
//   Optional (macro PIANOTILES_IO_BTN_IRQ_EN): BTN_STATUS (0x10, RO) and
//   BTN_EVENT (0x14, W1C) plus a level interrupt gated by REG1[0].
// Ports:
//   ACLK, ARESET       : clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*    : write address / data / response channels
//   S_AXI_AR*/R*       : read address / data channels
//   led_o              : registered copy of REG0[LED_W-1:0]
//   btn_i              : raw buttons (feature only)
//   irq_o              : REG1[0] & |BTN_EVENT, registered (0 without feature)
module pianotiles_io_axil_regs
  import pianotiles_io_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int LED_W              = 8,
  parameter int BTN_W              = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [LED_W-1:0]                led_o,
  input  logic [BTN_W-1:0]                btn_i,
  output logic                            irq_o
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;

`ifdef PIANOTILES_IO_BTN_IRQ_EN
  localparam bit BTN_FEAT = 1'b1;
`else
  localparam bit BTN_FEAT = 1'b0;
`endif

  logic [3:0][DW-1:0]  regs;

  // write channel skid state
  logic                aw_full, w_full;
  logic [AW-1:0]       aw_addr;
  logic [DW-1:0]       w_data;
  logic [DW/8-1:0]     w_strb;
  logic                bvalid;
  logic [1:0]          bresp;

  logic                rvalid;
  logic [1:0]          rresp;
  logic [DW-1:0]       rdata;

  logic                aw_hs, w_hs, ar_hs, wr_fire, wr_ok;
  logic [AW-1:0]       wr_addr;
  logic [DW-1:0]       wr_data, wr_mask;
  reg_idx_t            wr_idx, rd_idx;
  logic [DW-1:0]       rd_val;
  logic                rd_ok;

  logic [BTN_W-1:0]    btn_sync, btn_event;

  // READYs are forced low while ARESET is high and rise as soon as it drops.
  assign S_AXI_AWREADY = !ARESET && !aw_full && !bvalid;
  assign S_AXI_WREADY  = !ARESET && !w_full  && !bvalid;
  assign S_AXI_ARREADY = !ARESET && !rvalid;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // The write commits on the same edge that captures the later of AW/W, so
  // the live channel bypasses its holding register.
  assign wr_addr = aw_full ? aw_addr : S_AXI_AWADDR;
  assign wr_data = w_full  ? w_data  : S_AXI_WDATA;
  assign wr_mask = strb_mask(w_full ? w_strb : S_AXI_WSTRB);
  assign wr_fire = !bvalid && (aw_full || aw_hs) && (w_full || w_hs);
  assign wr_idx  = off_to_idx(wr_addr[4:0]);
  assign wr_ok   = (wr_idx <= IDX_REG3) ||
                   (BTN_FEAT && (wr_idx == IDX_BTN_STATUS || wr_idx == IDX_BTN_EVENT));

  assign rd_idx  = off_to_idx(S_AXI_ARADDR[4:0]);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else if (wr_fire) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      bvalid  <= 1'b1;
      bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (bvalid && S_AXI_BREADY) bvalid <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) regs <= '0;
    else if (wr_fire && wr_idx <= IDX_REG3)
      regs[wr_idx[1:0]] <= (regs[wr_idx[1:0]] & ~wr_mask) | (wr_data & wr_mask);
  end

  always_comb begin
    rd_val = '0;
    rd_ok  = 1'b1;
    case (rd_idx)
      IDX_REG0, IDX_REG1, IDX_REG2, IDX_REG3: rd_val = regs[rd_idx[1:0]];
`ifdef PIANOTILES_IO_BTN_IRQ_EN
      IDX_BTN_STATUS: rd_val = DW'(btn_sync);
      IDX_BTN_EVENT:  rd_val = DW'(btn_event);
`endif
      default:        rd_ok  = 1'b0;
    endcase
  end

  // Nonblocking capture: a write landing on the same edge is not yet visible.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_ok ? rd_val : '0;
      rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid && S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) led_o <= '0;
    else        led_o <= regs[0][LED_W-1:0];
  end

`ifdef PIANOTILES_IO_BTN_IRQ_EN
  logic [BTN_W-1:0] btn_rise, btn_clr;

  for (genvar g = 0; g < BTN_W; g++) begin : g_btn
    pianotiles_btn_sync u_sync (
      .clk     (ACLK),
      .rst     (ARESET),
      .async_i (btn_i[g]),
      .sync_o  (btn_sync[g]),
      .rise_o  (btn_rise[g])
    );
  end

  assign btn_clr = (wr_fire && wr_idx == IDX_BTN_EVENT) ?
                   (wr_data[BTN_W-1:0] & wr_mask[BTN_W-1:0]) : '0;

  // Set after clear so a same-cycle edge is never lost.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      btn_event <= '0;
      irq_o     <= 1'b0;
    end else begin
      btn_event <= (btn_event & ~btn_clr) | btn_rise;
      irq_o     <= regs[1][0] & |btn_event;
    end
  end
`else
  assign btn_sync  = '0;
  assign btn_event = '0;
  assign irq_o     = 1'b0;
`endif

  logic unused_sig;
  assign unused_sig = ^{S_AXI_AWPROT, S_AXI_ARPROT, btn_i, btn_sync, btn_event,
                        wr_addr, S_AXI_ARADDR};

  assign S_AXI_BVALID = bvalid;
  assign S_AXI_BRESP  = bresp;
  assign S_AXI_RVALID = rvalid;
  assign S_AXI_RRESP  = rresp;
  assign S_AXI_RDATA  = rdata;

endmodule

// File: tb/tb_pianotiles_io_axil_regs.sv
// Self-checking bench for pianotiles_io_axil_regs. Expected responses are
// queued when a transaction is launched and popped when the DUT answers.
module tb_pianotiles_io_axil_regs;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [4:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic [7:0]  led_o;
  logic [3:0]  btn_i;
  logic        irq_o;

  pianotiles_io_axil_regs dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .led_o(led_o), .btn_i(btn_i), .irq_o(irq_o)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          vecs = 0;
  int          errs = 0;
  logic [31:0] mdl[4];

  // Bus driver: returns response, cycles from last handshake to BVALID, and
  // whether BVALID/BRESP held and AW/W READY stayed low during the stall.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_d, input int w_d,
                           input int b_d, output logic [1:0] resp,
                           output int lat, output bit ok);
    bit aw_done = 0, w_done = 0, tmo = 0;
    int c = 0;
    logic [1:0] r0;
    ok = 1; lat = 0; resp = 'x;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(aw_done && w_done)) begin
      @(negedge ACLK);
      if (c > 60) begin tmo = 1; break; end
      S_AXI_AWVALID = !aw_done && (c >= aw_d);
      S_AXI_WVALID  = !w_done  && (c >= w_d);
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
      if (S_AXI_WVALID && S_AXI_WREADY)   w_done  = 1;
      c++;
    end
    while (!tmo) begin
      @(negedge ACLK);
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0; lat++;
      if (S_AXI_BVALID) break;
      if (lat > 20) tmo = 1;
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    if (!tmo) begin
      r0 = S_AXI_BRESP;
      repeat (b_d) begin
        @(negedge ACLK);
        if (!S_AXI_BVALID || S_AXI_BRESP !== r0 || S_AXI_AWREADY || S_AXI_WREADY) ok = 0;
      end
      S_AXI_BREADY = 1; resp = S_AXI_BRESP;
      @(negedge ACLK);
      S_AXI_BREADY = 0;
      if (S_AXI_BVALID) ok = 0;
    end else ok = 0;
  endtask

  task automatic axi_read(input logic [4:0] addr, input int r_d,
                          output logic [31:0] data, output logic [1:0] resp,
                          output int lat, output bit ok);
    bit tmo = 1;
    logic [31:0] d0;
    logic [1:0] r0;
    ok = 1; lat = 0; data = 'x; resp = 'x;
    S_AXI_ARADDR = addr;
    for (int c = 0; c < 60; c++) begin
      @(negedge ACLK);
      S_AXI_ARVALID = 1;
      if (S_AXI_ARREADY) begin tmo = 0; break; end
    end
    if (!tmo) begin
      tmo = 1;
      for (int c = 0; c < 20; c++) begin
        @(negedge ACLK);
        S_AXI_ARVALID = 0; lat++;
        if (S_AXI_RVALID) begin tmo = 0; break; end
      end
    end
    S_AXI_ARVALID = 0;
    if (!tmo) begin
      d0 = S_AXI_RDATA; r0 = S_AXI_RRESP;
      repeat (r_d) begin
        @(negedge ACLK);
        if (!S_AXI_RVALID || S_AXI_RDATA !== d0 || S_AXI_RRESP !== r0 || S_AXI_ARREADY) ok = 0;
      end
      S_AXI_RREADY = 1; data = S_AXI_RDATA; resp = S_AXI_RRESP;
      @(negedge ACLK);
      S_AXI_RREADY = 0;
      if (S_AXI_RVALID) ok = 0;
    end else ok = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic test_reset();
    logic [6:0] obs;
    ARESET = 1;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    S_AXI_AWADDR = 0; S_AXI_ARADDR = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0;
    S_AXI_AWPROT = 0; S_AXI_ARPROT = 0; btn_i = 0;
    for (int i = 0; i < 4; i++) mdl[i] = 0;
    repeat (3) @(negedge ACLK);
    obs = {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, irq_o, |led_o};
    vecs++;
    if (obs !== 7'b0) begin errs++; $display("FAIL reset_outputs: got %b expected 0000000", obs); end
    ARESET = 0;
    @(negedge ACLK);
    vecs++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      errs++; $display("FAIL ready_after_reset: got %b expected 111",
                       {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    vecs++;
    if ({S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP} !== 36'h0) begin
      errs++; $display("FAIL reset_data: got %h expected 0", {S_AXI_RDATA, S_AXI_RRESP, S_AXI_BRESP});
    end
  endtask

  task automatic test_basic();
    logic [1:0] r; logic [31:0] d; int lat; bit ok;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{OKAY, 32'h0});
      axi_write(5'(4*i), 32'(i + 1), 4'hF, 0, 0, 0, r, lat, ok);
      mdl[i] = 32'(i + 1);
      e = sb.pop_front(); vecs++;
      if (r !== e.resp) begin errs++; $display("FAIL basic_bresp[%0d]: got %b expected %b", i, r, e.resp); end
    end
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{OKAY, mdl[i]});
      axi_read(5'(4*i), 0, d, r, lat, ok);
      e = sb.pop_front(); vecs++;
      if (d !== e.data || r !== e.resp) begin
        errs++; $display("FAIL basic_read[%0d]: got %h/%b expected %h/%b", i, d, r, e.data, e.resp);
      end
      vecs++;
      if (lat !== 1) begin errs++; $display("FAIL read_latency[%0d]: got %0d expected 1", i, lat); end
    end
    vecs++;
    if (led_o !== 8'h01) begin errs++; $display("FAIL led: got %h expected 01", led_o); end
  endtask

  task automatic test_gap();
    logic [1:0] r; logic [31:0] d; int lat; bit ok;
    // AW first, W three cycles later
    sb.push_back('{OKAY, 32'h0});
    axi_write(5'h08, 32'hA5, 4'hF, 0, 3, 0, r, lat, ok);
    mdl[2] = 32'hA5;
    e = sb.pop_front(); vecs++;
    if (r !== e.resp || lat !== 1) begin
      errs++; $display("FAIL gap_aw_first: got resp %b lat %0d expected %b lat 1", r, lat, e.resp);
    end
    // W first, AW two cycles later
    sb.push_back('{OKAY, 32'h0});
    axi_write(5'h0C, 32'h5A, 4'hF, 2, 0, 0, r, lat, ok);
    mdl[3] = 32'h5A;
    e = sb.pop_front(); vecs++;
    if (r !== e.resp || lat !== 1) begin
      errs++; $display("FAIL gap_w_first: got resp %b lat %0d expected %b lat 1", r, lat, e.resp);
    end
    for (int i = 2; i < 4; i++) begin
      sb.push_back('{OKAY, mdl[i]});
      axi_read(5'(4*i), 0, d, r, lat, ok);
      e = sb.pop_front(); vecs++;
      if (d !== e.data || r !== e.resp) begin
        errs++; $display("FAIL gap_read[%0d]: got %h/%b expected %h/%b", i, d, r, e.data, e.resp);
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] r; logic [31:0] d; int lat; bit ok;
    axi_write(5'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, r, lat, ok);
    mdl[2] = 32'hFFFF_FFFF;
    sb.push_back('{OKAY, 32'h0});
    axi_write(5'h08, 32'h1234_5678, 4'b0101, 0, 0, 0, r, lat, ok);
    mdl[2] = merge(mdl[2], 32'h1234_5678, 4'b0101);
    e = sb.pop_front(); vecs++;
    if (r !== e.resp) begin errs++; $display("FAIL strobe_bresp: got %b expected %b", r, e.resp); end
    sb.push_back('{OKAY, 32'hFF34_FF78});
    axi_read(5'h08, 0, d, r, lat, ok);
    e = sb.pop_front(); vecs++;
    if (d !== e.data) begin errs++; $display("FAIL strobe_read: got %h expected %h", d, e.data); end
  endtask

  task automatic test_stall();
    logic [1:0] r; logic [31:0] d; int lat; bit ok;
    sb.push_back('{OKAY, 32'h0});
    axi_write(5'h04, 32'hC0DE_0002, 4'hF, 0, 0, 5, r, lat, ok);
    mdl[1] = 32'hC0DE_0002;
    e = sb.pop_front(); vecs++;
    if (r !== e.resp || ok !== 1'b1) begin
      errs++; $display("FAIL b_stall: got resp %b held %0d expected %b held 1", r, ok, e.resp);
    end
    sb.push_back('{OKAY, mdl[1]});
    axi_read(5'h04, 5, d, r, lat, ok);
    e = sb.pop_front(); vecs++;
    if (d !== e.data || r !== e.resp || ok !== 1'b1) begin
      errs++; $display("FAIL r_stall: got %h/%b held %0d expected %h/%b held 1", d, r, ok, e.data, e.resp);
    end
  endtask

  task automatic test_unmapped();
    logic [1:0] r; logic [31:0] d; int lat; bit ok;
    logic [4:0] offs[3];
    offs[0] = 5'h18; offs[1] = 5'h1C;
`ifdef PIANOTILES_IO_BTN_IRQ_EN
    offs[2] = 5'h1A;
`else
    offs[2] = 5'h10;
`endif
    sb.push_back('{SLVERR, 32'h0});
    axi_write(5'h18, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, r, lat, ok);
    e = sb.pop_front(); vecs++;
    if (r !== e.resp) begin errs++; $display("FAIL unmapped_bresp: got %b expected %b", r, e.resp); end
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{SLVERR, 32'h0});
      axi_read(offs[k], 0, d, r, lat, ok);
      e = sb.pop_front(); vecs++;
      if (d !== e.data || r !== e.resp) begin
        errs++; $display("FAIL unmapped_read[%h]: got %h/%b expected %h/%b", offs[k], d, r, e.data, e.resp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{OKAY, mdl[i]});
      axi_read(5'(4*i), 0, d, r, lat, ok);
      e = sb.pop_front(); vecs++;
      if (d !== e.data || r !== e.resp) begin
        errs++; $display("FAIL unmapped_intact[%0d]: got %h/%b expected %h/%b", i, d, r, e.data, e.resp);
      end
    end
  endtask

  // AW, W and AR all hit REG3 on one edge: the read must see the old value.
  task automatic test_same_edge();
    logic [1:0] r; logic [31:0] d; int lat; bit ok;
    sb.push_back('{OKAY, mdl[3]});
    @(negedge ACLK);
    S_AXI_AWADDR = 5'h0C; S_AXI_ARADDR = 5'h0C;
    S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
    @(negedge ACLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    e = sb.pop_front(); vecs++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== e.data || S_AXI_BVALID !== 1'b1) begin
      errs++; $display("FAIL same_edge_old: got rv %b %h bv %b expected 1 %h 1",
                       S_AXI_RVALID, S_AXI_RDATA, S_AXI_BVALID, e.data);
    end
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    @(negedge ACLK);
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    mdl[3] = 32'h0BAD_F00D;
    sb.push_back('{OKAY, mdl[3]});
    axi_read(5'h0C, 0, d, r, lat, ok);
    e = sb.pop_front(); vecs++;
    if (d !== e.data) begin errs++; $display("FAIL same_edge_new: got %h expected %h", d, e.data); end
  endtask

  // A latched AW is discarded by reset; a later lone W must not complete.
  task automatic test_reset_abort();
    logic [1:0] r; logic [31:0] d; int lat; bit ok; bit spurious = 0;
    @(negedge ACLK);
    S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1;
    @(negedge ACLK);
    S_AXI_AWVALID = 0; ARESET = 1;
    @(negedge ACLK);
    ARESET = 0;
    for (int i = 0; i < 4; i++) mdl[i] = 0;
    S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
    @(negedge ACLK);
    S_AXI_WVALID = 0;
    repeat (4) begin @(negedge ACLK); if (S_AXI_BVALID) spurious = 1; end
    vecs++;
    if (spurious !== 1'b0) begin errs++; $display("FAIL abort_no_resp: got %0d expected 0", spurious); end
    sb.push_back('{OKAY, 32'h0});
    S_AXI_AWADDR = 5'h0C; S_AXI_AWVALID = 1;
    @(negedge ACLK);
    S_AXI_AWVALID = 0;
    e = sb.pop_front(); vecs++;
    if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== e.resp) begin
      errs++; $display("FAIL abort_complete: got %b/%b expected 1/%b", S_AXI_BVALID, S_AXI_BRESP, e.resp);
    end
    S_AXI_BREADY = 1;
    @(negedge ACLK);
    S_AXI_BREADY = 0;
    mdl[3] = 32'h77;
    for (int i = 0; i < 4; i += 3) begin
      sb.push_back('{OKAY, mdl[i]});
      axi_read(5'(4*i), 0, d, r, lat, ok);
      e = sb.pop_front(); vecs++;
      if (d !== e.data) begin errs++; $display("FAIL abort_read[%0d]: got %h expected %h", i, d, e.data); end
    end
  endtask

`ifdef PIANOTILES_IO_BTN_IRQ_EN
  task automatic test_btn_irq();
    logic [1:0] r; logic [31:0] d; int lat; bit ok; int cyc = 0;
    axi_write(5'h04, 32'h1, 4'hF, 0, 0, 0, r, lat, ok);
    mdl[1] = 32'h1;
    @(negedge ACLK);
    btn_i = 4'b0100;
    while (!irq_o && cyc < 8) begin @(negedge ACLK); cyc++; end
    vecs++;
    if (irq_o !== 1'b1 || cyc > 4) begin
      errs++; $display("FAIL irq_rise: got irq %b after %0d cycles expected 1 within 4", irq_o, cyc);
    end
    sb.push_back('{OKAY, 32'h4});
    axi_read(5'h10, 0, d, r, lat, ok);
    e = sb.pop_front(); vecs++;
    if (d !== e.data || r !== e.resp) begin
      errs++; $display("FAIL btn_status: got %h/%b expected %h/%b", d, r, e.data, e.resp);
    end
    btn_i = 4'b0000;
    repeat (4) @(negedge ACLK);
    sb.push_back('{OKAY, 32'h4});
    axi_read(5'h14, 0, d, r, lat, ok);
    e = sb.pop_front(); vecs++;
    if (d !== e.data) begin errs++; $display("FAIL btn_event_set: got %h expected %h", d, e.data); end
    sb.push_back('{OKAY, 32'h0});
    axi_write(5'h10, 32'hF, 4'hF, 0, 0, 0, r, lat, ok);
    e = sb.pop_front(); vecs++;
    if (r !== e.resp) begin errs++; $display("FAIL status_write_resp: got %b expected %b", r, e.resp); end
    axi_write(5'h14, 32'h4, 4'hF, 0, 0, 0, r, lat, ok);
    sb.push_back('{OKAY, 32'h0});
    axi_read(5'h14, 0, d, r, lat, ok);
    e = sb.pop_front(); vecs++;
    if (d !== e.data) begin errs++; $display("FAIL btn_event_clr: got %h expected %h", d, e.data); end
    vecs++;
    if (irq_o !== 1'b0) begin errs++; $display("FAIL irq_clr: got %b expected 0", irq_o); end
  endtask
`else
  task automatic test_btn_irq();
    logic [1:0] r; logic [31:0] d; int lat; bit ok;
    btn_i = 4'hF;
    sb.push_back('{SLVERR, 32'h0});
    axi_read(5'h14, 0, d, r, lat, ok);
    e = sb.pop_front(); vecs++;
    if (d !== e.data || r !== e.resp) begin
      errs++; $display("FAIL btn_event_unmapped: got %h/%b expected %h/%b", d, r, e.data, e.resp);
    end
    vecs++;
    if (irq_o !== 1'b0) begin errs++; $display("FAIL irq_tied: got %b expected 0", irq_o); end
    btn_i = 4'h0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_strobe();
    test_stall();
    test_unmapped();
    test_same_edge();
    test_reset_abort();
    test_btn_irq();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
